// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: decoded-instruction, forwarding and ALU-input bus of the issue stage
interface alu_issue_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1_addr;
    logic [4:0]      in_rs2_addr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic [1:0]      in_a_sel;
    logic [1:0]      in_b_sel;
    logic            in_is_store;
    logic [4:0]      in_alu_op;
    logic [4:0]      in_rd_addr;
    logic            in_reg_write;
    logic            ex_fwd_valid;
    logic [4:0]      ex_fwd_rd;
    logic [XLEN-1:0] ex_fwd_data;
    logic            ex_is_load;
    logic            wb_fwd_valid;
    logic [4:0]      wb_fwd_rd;
    logic [XLEN-1:0] wb_fwd_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd_addr;
    logic            out_reg_write;
    logic [XLEN-1:0] out_pc;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm,
               in_a_sel, in_b_sel, in_is_store, in_alu_op, in_rd_addr, in_reg_write,
               ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_is_load,
               wb_fwd_valid, wb_fwd_rd, wb_fwd_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, out_store_data, out_rd_addr,
               out_reg_write, out_pc, stall_cnt
    );

    modport master (
        output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data, in_imm,
               in_a_sel, in_b_sel, in_is_store, in_alu_op, in_rd_addr, in_reg_write,
               ex_fwd_valid, ex_fwd_rd, ex_fwd_data, ex_is_load,
               wb_fwd_valid, wb_fwd_rd, wb_fwd_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, out_store_data, out_rd_addr,
               out_reg_write, out_pc, stall_cnt
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage with operand forwarding, load-use stall and ALU input register
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic              clk,
    input logic              reset,
    alu_issue_stage_if.slave bus
);
    logic [XLEN-1:0] rs1_val, rs2_val, a_val, b_val;
    logic            rs1_used, rs2_used, hazard, ready, accept;

    assign bus.in_ready = ready;

    // Forward EX over WB over register file, pick operands, detect load-use hazard
    always_comb begin
        rs1_val  = bus.in_rs1_addr == 5'd0 ? '0 :
                   (bus.ex_fwd_valid && !bus.ex_is_load && bus.ex_fwd_rd == bus.in_rs1_addr) ? bus.ex_fwd_data :
                   (bus.wb_fwd_valid && bus.wb_fwd_rd == bus.in_rs1_addr) ? bus.wb_fwd_data : bus.in_rs1_data;
        rs2_val  = bus.in_rs2_addr == 5'd0 ? '0 :
                   (bus.ex_fwd_valid && !bus.ex_is_load && bus.ex_fwd_rd == bus.in_rs2_addr) ? bus.ex_fwd_data :
                   (bus.wb_fwd_valid && bus.wb_fwd_rd == bus.in_rs2_addr) ? bus.wb_fwd_data : bus.in_rs2_data;
        a_val    = bus.in_a_sel == 2'd0 ? rs1_val : bus.in_a_sel == 2'd1 ? bus.in_pc : '0;
        b_val    = bus.in_b_sel == 2'd0 ? rs2_val : bus.in_b_sel == 2'd1 ? bus.in_imm :
                   bus.in_b_sel == 2'd2 ? XLEN'(4) : '0;
        rs1_used = bus.in_a_sel == 2'd0;
        rs2_used = bus.in_b_sel == 2'd0 || bus.in_is_store;
        hazard   = bus.in_valid && bus.ex_fwd_valid && bus.ex_is_load && bus.ex_fwd_rd != 5'd0 &&
                   ((rs1_used && bus.ex_fwd_rd == bus.in_rs1_addr) || (rs2_used && bus.ex_fwd_rd == bus.in_rs2_addr));
        ready    = !bus.flush && !hazard && (!bus.out_valid || bus.out_ready);
        accept   = bus.in_valid && ready;
    end

    // ALU input register: capture on accept, drop on drain or flush, count stall cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid      <= 1'b0;
            bus.alu_a          <= '0;
            bus.alu_b          <= '0;
            bus.alu_op         <= '0;
            bus.out_store_data <= '0;
            bus.out_rd_addr    <= '0;
            bus.out_reg_write  <= 1'b0;
            bus.out_pc         <= '0;
            bus.stall_cnt      <= '0;
        end else begin
            if (hazard) bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
            if (accept) begin
                bus.out_valid      <= 1'b1;
                bus.alu_a          <= a_val;
                bus.alu_b          <= b_val;
                bus.alu_op         <= bus.in_alu_op;
                bus.out_store_data <= rs2_val;
                bus.out_rd_addr    <= bus.in_rd_addr;
                bus.out_reg_write  <= bus.in_reg_write;
                bus.out_pc         <= bus.in_pc;
            end else if (bus.flush || bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random checks of alu_issue_stage against a spec-level model
module tb_alu_issue_stage;
    localparam logic [4:0] ADD = 5'h01;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    logic        m_v, m_rw;
    logic [31:0] m_a, m_b, m_sd, m_pc, m_cnt;
    logic [4:0]  m_op, m_rd;

    alu_issue_stage_if #(.XLEN(32), .CNT_W(32)) bus ();
    alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_src(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 0) return 0;
        if (bus.ex_fwd_valid && !bus.ex_is_load && bus.ex_fwd_rd == addr) return bus.ex_fwd_data;
        if (bus.wb_fwd_valid && bus.wb_fwd_rd == addr) return bus.wb_fwd_data;
        return rf;
    endfunction

    function automatic logic ref_hazard();
        logic u1, u2;
        u1 = bus.in_a_sel == 0;
        u2 = bus.in_b_sel == 0 || bus.in_is_store;
        return bus.in_valid && bus.ex_fwd_valid && bus.ex_is_load && bus.ex_fwd_rd != 0 &&
               ((u1 && bus.ex_fwd_rd == bus.in_rs1_addr) || (u2 && bus.ex_fwd_rd == bus.in_rs2_addr));
    endfunction

    task automatic model_reset();
        m_v = 0; m_rw = 0; m_a = 0; m_b = 0; m_sd = 0; m_pc = 0; m_cnt = 0; m_op = 0; m_rd = 0;
    endtask

    task automatic clear();
        bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1_addr = 0; bus.in_rs2_addr = 0;
        bus.in_rs1_data = 0; bus.in_rs2_data = 0; bus.in_imm = 0; bus.in_a_sel = 0; bus.in_b_sel = 0;
        bus.in_is_store = 0; bus.in_alu_op = 0; bus.in_rd_addr = 0; bus.in_reg_write = 0;
        bus.ex_fwd_valid = 0; bus.ex_fwd_rd = 0; bus.ex_fwd_data = 0; bus.ex_is_load = 0;
        bus.wb_fwd_valid = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0; bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic rand_in();
        bus.in_valid = $urandom_range(0, 3) != 0; bus.in_pc = $urandom;
        bus.in_rs1_addr = 5'($urandom_range(0, 7)); bus.in_rs2_addr = 5'($urandom_range(0, 7));
        bus.in_rs1_data = $urandom; bus.in_rs2_data = $urandom; bus.in_imm = $urandom;
        bus.in_a_sel = 2'($urandom); bus.in_b_sel = 2'($urandom); bus.in_is_store = 1'($urandom);
        bus.in_alu_op = 5'($urandom); bus.in_rd_addr = 5'($urandom); bus.in_reg_write = 1'($urandom);
        bus.ex_fwd_valid = 1'($urandom); bus.ex_fwd_rd = 5'($urandom_range(0, 7));
        bus.ex_fwd_data = $urandom; bus.ex_is_load = 1'($urandom);
        bus.wb_fwd_valid = 1'($urandom); bus.wb_fwd_rd = 5'($urandom_range(0, 7));
        bus.wb_fwd_data = $urandom; bus.flush = $urandom_range(0, 7) == 0;
        bus.out_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic cyc();
        logic hz, rdy;
        logic [31:0] r1, r2;
        #1;
        hz  = ref_hazard();
        rdy = !bus.flush && !hz && (!m_v || bus.out_ready);
        r1  = ref_src(bus.in_rs1_addr, bus.in_rs1_data);
        r2  = ref_src(bus.in_rs2_addr, bus.in_rs2_data);
        chk("in_ready", bus.in_ready, rdy);
        @(posedge clk);
        if (hz) m_cnt = m_cnt + 1;
        if (bus.in_valid && rdy) begin
            m_v  = 1;
            m_a  = bus.in_a_sel == 0 ? r1 : bus.in_a_sel == 1 ? bus.in_pc : 0;
            case (bus.in_b_sel)
                2'd0: m_b = r2;
                2'd1: m_b = bus.in_imm;
                2'd2: m_b = 4;
                default: m_b = 0;
            endcase
            m_sd = r2; m_op = bus.in_alu_op; m_rd = bus.in_rd_addr;
            m_rw = bus.in_reg_write; m_pc = bus.in_pc;
        end else if (bus.flush) m_v = 0;
        else if (m_v && bus.out_ready) m_v = 0;
        #1;
        chk("out_valid", bus.out_valid, m_v);
        chk("stall_cnt", bus.stall_cnt, m_cnt);
        if (m_v) begin
            chk("alu_a", bus.alu_a, m_a);
            chk("alu_b", bus.alu_b, m_b);
            chk("alu_op", bus.alu_op, m_op);
            chk("store_data", bus.out_store_data, m_sd);
            chk("rd_addr", bus.out_rd_addr, m_rd);
            chk("reg_write", bus.out_reg_write, m_rw);
            chk("out_pc", bus.out_pc, m_pc);
        end
    endtask

    initial begin
        clear();
        model_reset();
        #12;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_a", bus.alu_a, 0);
        chk("rst_b", bus.alu_b, 0);
        chk("rst_sd", bus.out_store_data, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_cnt", bus.stall_cnt, 0);
        chk("rst_op", bus.alu_op, 0);
        chk("rst_rd", bus.out_rd_addr, 0);
        chk("rst_rw", bus.out_reg_write, 0);
        reset = 0;

        // ADD x3,x1,x2
        bus.in_valid = 1; bus.in_rs1_addr = 1; bus.in_rs2_addr = 2; bus.in_rs1_data = 5;
        bus.in_rs2_data = 7; bus.in_alu_op = ADD; bus.in_rd_addr = 3; bus.in_reg_write = 1;
        cyc();
        chk("add_valid", bus.out_valid, 1);
        chk("add_a", bus.alu_a, 5);
        chk("add_b", bus.alu_b, 7);
        chk("add_op", bus.alu_op, ADD);
        chk("add_rd", bus.out_rd_addr, 3);

        // EX over WB priority, then WB only, then x0
        bus.in_rs1_addr = 4; bus.in_rs1_data = 32'h30;
        bus.ex_fwd_valid = 1; bus.ex_fwd_rd = 4; bus.ex_fwd_data = 32'h10;
        bus.wb_fwd_valid = 1; bus.wb_fwd_rd = 4; bus.wb_fwd_data = 32'h20;
        cyc();
        chk("fwd_ex", bus.alu_a, 32'h10);
        bus.ex_fwd_valid = 0;
        cyc();
        chk("fwd_wb", bus.alu_a, 32'h20);
        bus.in_rs1_addr = 0; bus.ex_fwd_valid = 1; bus.ex_fwd_rd = 0; bus.wb_fwd_rd = 0;
        cyc();
        chk("fwd_x0", bus.alu_a, 0);

        // load-use stall on rs2
        clear();
        bus.in_valid = 1; bus.in_rs2_addr = 6; bus.in_rs2_data = 32'h55;
        bus.ex_fwd_valid = 1; bus.ex_is_load = 1; bus.ex_fwd_rd = 6;
        #1;
        chk("lu_ready", bus.in_ready, 0);
        cyc();
        chk("lu_cnt", bus.stall_cnt, 1);
        bus.ex_fwd_valid = 0; bus.ex_is_load = 0;
        bus.wb_fwd_valid = 1; bus.wb_fwd_rd = 6; bus.wb_fwd_data = 32'hAB;
        cyc();
        chk("lu_b", bus.alu_b, 32'hAB);
        bus.wb_fwd_valid = 0; bus.ex_fwd_valid = 1; bus.ex_is_load = 1; bus.in_b_sel = 1;
        #1;
        chk("nolu_ready", bus.in_ready, 1);
        cyc();
        chk("nolu_cnt", bus.stall_cnt, 1);

        // backpressure
        clear();
        bus.in_valid = 1; bus.in_rs1_addr = 1; bus.in_rs1_data = 32'h111; bus.in_rd_addr = 7;
        cyc();
        bus.out_ready = 0; bus.in_rs1_data = 32'h222; bus.in_rd_addr = 8;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_hold_a", bus.alu_a, 32'h111);
            chk("bp_hold_rd", bus.out_rd_addr, 7);
            chk("bp_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1;
        cyc();
        chk("bp_b_a", bus.alu_a, 32'h222);
        chk("bp_b_rd", bus.out_rd_addr, 8);

        // flush with held and incoming instruction
        bus.in_rs1_data = 32'h333; bus.flush = 1;
        #1;
        chk("fl_ready", bus.in_ready, 0);
        cyc();
        chk("fl_valid", bus.out_valid, 0);
        bus.flush = 0;

        // pc / const4
        clear();
        bus.in_valid = 1; bus.in_a_sel = 1; bus.in_b_sel = 2; bus.in_pc = 32'h100;
        cyc();
        chk("pc_a", bus.alu_a, 32'h100);
        chk("c4_b", bus.alu_b, 4);

        // async reset during a hold
        bus.out_ready = 0; bus.in_valid = 1; bus.in_a_sel = 0; bus.in_rs1_addr = 6;
        bus.ex_fwd_valid = 1; bus.ex_is_load = 1; bus.ex_fwd_rd = 6;
        cyc();
        #2;
        reset = 1;
        #1;
        chk("ar_valid", bus.out_valid, 0);
        chk("ar_cnt", bus.stall_cnt, 0);
        model_reset();
        #2;
        reset = 0;
        clear();

        for (int i = 0; i < 600; i++) begin
            rand_in();
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary stage directly upstream of the ALU.
- Accepts a decoded instruction and resolves operand forwarding from the EX and WB stages.
- Selects the ALU a/b operands and registers them, with op and destination, into the ALU input register.
- Provides a valid/ready handshake, load-use stall detection, flush, and a stall counter.

Parameters:
- XLEN, 32, datapath width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1_addr  in  5  source register 1 index
- in_rs2_addr  in  5  source register 2 index
- in_rs1_data  in  XLEN  register-file read data for rs1
- in_rs2_data  in  XLEN  register-file read data for rs2
- in_imm  in  XLEN  sign-extended immediate
- in_a_sel  in  2  a source: 0=rs1, 1=pc, 2=zero, 3=zero
- in_b_sel  in  2  b source: 0=rs2, 1=imm, 2=constant 4, 3=zero
- in_is_store  in  1  instruction consumes rs2 as store data
- in_alu_op  in  5  ALU operation code
- in_rd_addr  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- ex_fwd_valid  in  1  EX-stage result writes a register
- ex_fwd_rd  in  5  EX destination register
- ex_fwd_data  in  XLEN  EX result
- ex_is_load  in  1  EX instruction is a load; data not yet available
- wb_fwd_valid  in  1  WB writes a register
- wb_fwd_rd  in  5  WB destination register
- wb_fwd_data  in  XLEN  WB data
- flush  in  1  squash the held and incoming instruction
- out_valid  out  1  ALU input register holds a valid instruction
- out_ready  in  1  downstream consumes the instruction
- alu_a  out  XLEN  ALU operand a
- alu_b  out  XLEN  ALU operand b
- alu_op  out  5  ALU operation code
- out_store_data  out  XLEN  forwarded rs2 value
- out_rd_addr  out  5  destination register
- out_reg_write  out  1  write enable
- out_pc  out  XLEN  PC
- stall_cnt  out  CNT_W  count of load-use stall cycles

Behaviour:
- Reset (async, active-high):
  - out_valid=0.
  - alu_a, alu_b, out_store_data, out_pc, stall_cnt = 0.
  - alu_op=0, out_rd_addr=0, out_reg_write=0.
- Forwarding (combinational, per source s in {rs1, rs2}):
  - s_addr==0 -> value 0.
  - else ex_fwd_valid && !ex_is_load && ex_fwd_rd==s_addr -> ex_fwd_data.
  - else wb_fwd_valid && wb_fwd_rd==s_addr -> wb_fwd_data.
  - else register-file data.
  - EX has priority over WB.
- Usage:
  - rs1_used = (in_a_sel==0).
  - rs2_used = (in_b_sel==0) || in_is_store.
- Hazard = in_valid && ex_fwd_valid && ex_is_load && ex_fwd_rd!=0 && ((rs1_used && ex_fwd_rd==in_rs1_addr) || (rs2_used && ex_fwd_rd==in_rs2_addr)).
- Ready:
  - in_ready = !flush && !hazard && (!out_valid || out_ready).
  - No combinational path from in_valid to in_ready other than through hazard.
- Accept (in_valid && in_ready):
  - Next edge loads alu_a/alu_b from the selected forwarded sources.
  - out_store_data loads forwarded rs2; remaining fields load from inputs.
  - out_valid=1.
- Operands are resolved only at acceptance. Held values are frozen and never re-forwarded.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0 next edge. Data fields may hold stale values.
- Backpressure: out_valid && !out_ready -> all outputs stable; in_ready=0.
- Flush:
  - Overrides everything: out_valid=0 next edge; incoming instruction dropped (in_ready=0).
  - stall_cnt still counts if a hazard is present in the same cycle.
- stall_cnt:
  - Increments by 1 every cycle hazard==1, regardless of out_ready.
  - Wraps at 2^CNT_W.
- Latency: one cycle from acceptance to out_valid. Throughput: one instruction per cycle with no stalls.
- Arithmetic:
  - b constant 4 is zero-extended to XLEN.
  - All selections are width-exact; no truncation.

Test Plan:
- ADD x3,x1,x2 with rs1_data=5, rs2_data=7, a_sel=0, b_sel=0, no forwards -> next cycle out_valid=1, alu_a=5, alu_b=7, alu_op=ADD, out_rd_addr=3.
- rs1=x4 with ex_fwd(rd=4, data=0x10) and wb_fwd(rd=4, data=0x20), rf=0x30 -> alu_a=0x10.
- Same case with EX invalid -> alu_a=0x20. rs1=x0 with both forwards rd=0 -> alu_a=0.
- Load-use:
  - ex_is_load=1, ex_fwd_rd=6, in rs2=6, b_sel=0 -> in_ready=0 for one cycle, stall_cnt 0->1.
  - Next cycle wb_fwd(rd=6, data=0xAB) -> accepted with alu_b=0xAB.
  - The same hazard with b_sel=1 and in_is_store=0 -> no stall.
- Backpressure:
  - Accept instr A, hold out_ready=0 for 3 cycles while in_valid=1 with B -> outputs remain A, in_ready=0.
  - out_ready=1 -> B loaded next edge.
- Flush while out_valid=1 and in_valid=1 -> next cycle out_valid=0, B not captured.
- Assert reset mid-hold -> out_valid and stall_cnt 0 immediately, without waiting for a clock edge.
- pc/const4 select: a_sel=1, b_sel=2, pc=0x100 -> alu_a=0x100, alu_b=4.
